// File: rtl/rr_mux.sv
// rr_mux: N-channel round-robin multiplexer with a registered output stage and valid/ready handshakes.
// Define RR_MUX_FIXED_PRIO_EN to build it with fixed lowest-index-first priority and no rotating pointer.
module rr_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);

    // Handshakes: a word moves on a channel when in_valid[i] && in_ready[i] at a rising clock edge.
    // The output word is consumed when out_valid && out_ready at a rising clock edge.

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    logic             free;
    logic             found;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] start;
    logic             accept;

`ifdef RR_MUX_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [SEL_W-1:0] ptr_q, ptr_d;
    assign start = ptr_q;
`endif

    assign free   = !out_valid_q || out_ready;
    assign accept = found && free;

    // Search from start upward; the modulo keeps the index inside 0..CHANNELS-1.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(start) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

    // No handshake may complete while reset is held.
    always_comb begin
        in_ready = '0;
        if (accept && !reset) begin
            in_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[int'(winner)*WIDTH +: WIDTH];
            out_sel_d   = winner;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifndef RR_MUX_FIXED_PRIO_EN
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            if (int'(winner) == CHANNELS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux (WIDTH=8, CHANNELS=4, round-robin build); expected values are hand-computed.
module tb_rr_mux;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clock;
    logic                      reset;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    rr_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_sel"},   32'(out_sel),   32'(s));
    endtask

    logic [1:0] rot_sel [5];
    logic [7:0] rot_data[5];
    logic [3:0] rot_rdy [5];

    initial begin
        rot_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rot_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        rot_rdy  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        reset     = 1'b1;
        in_valid  = '0;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        out_ready = 1'b0;
        step();
        step();
        chk_out("reset", 1'b0, 8'h00, 2'd0);
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        reset = 1'b0;

        // Rotation with all channels valid and the output always drained
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rot_first_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("rot%0d", i), 1'b1, rot_data[i], rot_sel[i]);
            chk($sformatf("rot%0d_ready", i), 32'(in_ready), 32'(rot_rdy[i]));
        end

        // Backpressure: three stalled cycles, then drain and accept in one edge
        out_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("bp%0d", i), 1'b1, 8'hA0, 2'd0);
            chk($sformatf("bp%0d_ready", i), 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0010);
        step();
        chk_out("bp_accept", 1'b1, 8'hA1, 2'd1);

        // Sparse: channels 1 and 3 with ptr at 2
        in_valid = 4'b1010;
        #1;
        chk("sp_ready0", 32'(in_ready), 32'b1000);
        step();
        chk_out("sp0", 1'b1, 8'hA3, 2'd3);
        chk("sp_ready1", 32'(in_ready), 32'b0010);
        step();
        chk_out("sp1", 1'b1, 8'hA1, 2'd1);
        chk("sp_ready2", 32'(in_ready), 32'b1000);

        // Idle drain: ptr stays at 2 across the drain and an idle cycle
        in_valid = 4'b0000;
        #1;
        chk("drain_ready", 32'(in_ready), 32'h0);
        step();
        chk_out("drain", 1'b0, 8'hA1, 2'd1);
        step();
        chk_out("idle", 1'b0, 8'hA1, 2'd1);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        chk("post_drain_ready", 32'(in_ready), 32'b0100);
        step();
        chk_out("post_drain", 1'b1, 8'hA2, 2'd2);
        chk("stall_ready", 32'(in_ready), 32'h0);

        // Asynchronous reset mid-cycle while a word is held
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 8'h00, 2'd0);
        chk("async_rst_ready", 32'(in_ready), 32'h0);
        step();
        chk_out("rst_hold", 1'b0, 8'h00, 2'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_rel_ready", 32'(in_ready), 32'b0001);
        step();
        chk_out("rst_first", 1'b1, 8'hA0, 2'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
